// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: requester ids, arbiter states and the
// read-return tag carried alongside each outstanding VRAM read.
package vram_pkg;

    typedef enum logic [1:0] {
        SRC_SCAN = 2'd0,
        SRC_GPU  = 2'd1,
        SRC_CPU  = 2'd2
    } src_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic valid;
        src_e src;
    } rd_tag_t;

    localparam int TAG_W = $bits(rd_tag_t);
    localparam rd_tag_t TAG_NONE = '{valid: 1'b0, src: SRC_SCAN};

    function automatic rd_tag_t make_tag(input src_e src);
        rd_tag_t tag;
        tag.valid = 1'b1;
        tag.src   = src;
        return tag;
    endfunction

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Delay line of read tags matching the VRAM read latency, so each tag
// leaves the pipe in step with the data it describes.
module vram_rd_tag_pipe
    import vram_pkg::*;
#(
    parameter int MEM_LAT = 2
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [TAG_W-1:0] push_tag,
    output logic [TAG_W-1:0] out_tag
);

    rd_tag_t stage_r [MEM_LAT];

    // Shift tags one stage per cycle; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                stage_r[i] <= TAG_NONE;
            end
        end else begin
            stage_r[0] <= rd_tag_t'(push_tag);
            for (int i = 1; i < MEM_LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_tag = stage_r[MEM_LAT-1];

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between scanout (fixed-priority read bursts)
// and the GPU/CPU (round-robin single words), routing read data back by tag.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 2,
    parameter int BURST_LEN = 8
)(
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              sc_req,
    input  logic [ADDR_W-1:0] sc_addr,
    output logic              sc_ack,
    output logic              sc_rvalid,
    output logic              sc_done,
    input  logic              gpu_req,
    input  logic              gpu_we,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [DATA_W-1:0] gpu_wdata,
    output logic              gpu_ack,
    output logic              gpu_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    arb_state_e        state_r, state_nxt_s;
    logic [CNT_W-1:0]  count_r, count_nxt_s;
    logic [ADDR_W-1:0] base_r, base_nxt_s;
    logic              cpu_last_r, cpu_last_nxt_s;
    logic [CNT_W-1:0]  sc_rv_cnt_r, sc_rv_cnt_nxt_s;

    logic              sc_ok_s, gpu_ok_s, cpu_ok_s;
    logic              ce_s, we_s, sc_ack_s, gpu_ack_s, cpu_ack_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;
    rd_tag_t           push_tag_s, out_tag_s;
    logic [TAG_W-1:0]  out_tag_bits_s;
    logic              sc_rv_s, gpu_rv_s, cpu_rv_s, sc_done_s;

    logic              sc_ack_r, gpu_ack_r, cpu_ack_r;
    logic              sc_rvalid_r, gpu_rvalid_r, cpu_rvalid_r, sc_done_r;
    logic              mem_ce_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    // A requester acked this cycle is still showing its old request
    assign sc_ok_s  = sc_req  & ~sc_ack_r;
    assign gpu_ok_s = gpu_req & ~gpu_ack_r;
    assign cpu_ok_s = cpu_req & ~cpu_ack_r;

    // Command selection: scanout bursts first, then GPU/CPU alternation
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        base_nxt_s     = base_r;
        cpu_last_nxt_s = cpu_last_r;
        ce_s           = 1'b0;
        we_s           = 1'b0;
        addr_s         = mem_addr_r;
        wdata_s        = mem_wdata_r;
        sc_ack_s       = 1'b0;
        gpu_ack_s      = 1'b0;
        cpu_ack_s      = 1'b0;
        push_tag_s     = TAG_NONE;
        case (state_r)
            IDLE: begin
                if (sc_ok_s) begin
                    ce_s        = 1'b1;
                    addr_s      = sc_addr;
                    base_nxt_s  = sc_addr;
                    count_nxt_s = CNT_ONE;
                    sc_ack_s    = 1'b1;
                    push_tag_s  = make_tag(SRC_SCAN);
                    state_nxt_s = BURST;
                end else if (gpu_ok_s && (!cpu_ok_s || cpu_last_r)) begin
                    ce_s           = 1'b1;
                    we_s           = gpu_we;
                    addr_s         = gpu_addr;
                    wdata_s        = gpu_wdata;
                    gpu_ack_s      = 1'b1;
                    cpu_last_nxt_s = 1'b0;
                    if (gpu_we) begin
                        push_tag_s = TAG_NONE;
                    end else begin
                        push_tag_s = make_tag(SRC_GPU);
                    end
                end else if (cpu_ok_s) begin
                    ce_s           = 1'b1;
                    we_s           = cpu_we;
                    addr_s         = cpu_addr;
                    wdata_s        = cpu_wdata;
                    cpu_ack_s      = 1'b1;
                    cpu_last_nxt_s = 1'b1;
                    if (cpu_we) begin
                        push_tag_s = TAG_NONE;
                    end else begin
                        push_tag_s = make_tag(SRC_CPU);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                ce_s       = 1'b1;
                addr_s     = base_r + ADDR_W'(count_r);
                push_tag_s = make_tag(SRC_SCAN);
                if (count_r == LAST_CNT) begin
                    state_nxt_s = IDLE;
                    count_nxt_s = CNT_ZERO;
                end else begin
                    count_nxt_s = count_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                count_nxt_s = CNT_ZERO;
            end
        endcase
    end

    vram_rd_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk      (CLOCK_50),
        .reset    (reset),
        .push_tag (push_tag_s),
        .out_tag  (out_tag_bits_s)
    );

    assign out_tag_s = rd_tag_t'(out_tag_bits_s);

    // Decode the returning tag; count scanout words to flag the burst's last
    always_comb begin
        sc_rv_s         = 1'b0;
        gpu_rv_s        = 1'b0;
        cpu_rv_s        = 1'b0;
        sc_done_s       = 1'b0;
        sc_rv_cnt_nxt_s = sc_rv_cnt_r;
        if (out_tag_s.valid) begin
            case (out_tag_s.src)
                SRC_SCAN: begin
                    sc_rv_s = 1'b1;
                    if (sc_rv_cnt_r == LAST_CNT) begin
                        sc_done_s       = 1'b1;
                        sc_rv_cnt_nxt_s = CNT_ZERO;
                    end else begin
                        sc_rv_cnt_nxt_s = sc_rv_cnt_r + CNT_ONE;
                    end
                end
                SRC_GPU: begin
                    gpu_rv_s = 1'b1;
                end
                SRC_CPU: begin
                    cpu_rv_s = 1'b1;
                end
                default: begin
                    sc_rv_cnt_nxt_s = sc_rv_cnt_r;
                end
            endcase
        end else begin
            sc_rv_cnt_nxt_s = sc_rv_cnt_r;
        end
    end

    // State and registered outputs; the pointer starts out favouring the GPU
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r      <= IDLE;
            count_r      <= CNT_ZERO;
            base_r       <= {ADDR_W{1'b0}};
            cpu_last_r   <= 1'b1;
            sc_rv_cnt_r  <= CNT_ZERO;
            sc_ack_r     <= 1'b0;
            gpu_ack_r    <= 1'b0;
            cpu_ack_r    <= 1'b0;
            sc_rvalid_r  <= 1'b0;
            gpu_rvalid_r <= 1'b0;
            cpu_rvalid_r <= 1'b0;
            sc_done_r    <= 1'b0;
            mem_ce_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            base_r       <= base_nxt_s;
            cpu_last_r   <= cpu_last_nxt_s;
            sc_rv_cnt_r  <= sc_rv_cnt_nxt_s;
            sc_ack_r     <= sc_ack_s;
            gpu_ack_r    <= gpu_ack_s;
            cpu_ack_r    <= cpu_ack_s;
            sc_rvalid_r  <= sc_rv_s;
            gpu_rvalid_r <= gpu_rv_s;
            cpu_rvalid_r <= cpu_rv_s;
            sc_done_r    <= sc_done_s;
            mem_ce_r     <= ce_s;
            mem_we_r     <= we_s;
            mem_addr_r   <= addr_s;
            mem_wdata_r  <= wdata_s;
        end
    end

    assign sc_ack     = sc_ack_r;
    assign gpu_ack    = gpu_ack_r;
    assign cpu_ack    = cpu_ack_r;
    assign sc_rvalid  = sc_rvalid_r;
    assign gpu_rvalid = gpu_rvalid_r;
    assign cpu_rvalid = cpu_rvalid_r;
    assign sc_done    = sc_done_r;
    assign mem_ce     = mem_ce_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign rdata      = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_vram_arbiter;

    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 16;
    localparam int MEM_LAT   = 2;
    localparam int BURST_LEN = 8;

    logic              CLOCK_50 = 1'b0;
    logic              reset = 1'b1;
    logic              sc_req = 1'b0, gpu_req = 1'b0, cpu_req = 1'b0;
    logic              gpu_we = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] sc_addr = '0, gpu_addr = '0, cpu_addr = '0;
    logic [DATA_W-1:0] gpu_wdata = '0, cpu_wdata = '0, mem_rdata = '0;
    logic              sc_ack, sc_rvalid, sc_done, gpu_ack, gpu_rvalid;
    logic              cpu_ack, cpu_rvalid, mem_ce, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DATA_W-1:0] env_mem [int];
    logic [DATA_W-1:0] ref_mem [int];
    logic [DATA_W-1:0] env_due [int];

    // Reference-model state for the randomized run
    int                m_left;
    logic [ADDR_W-1:0] m_baddr;
    logic              m_sc_ack, m_gpu_ack, m_cpu_ack, m_cpu_last;
    int                exp_src  [int];
    logic [DATA_W-1:0] exp_data [int];
    bit                exp_last [int];

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .BURST_LEN(BURST_LEN)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .sc_req(sc_req), .sc_addr(sc_addr), .sc_ack(sc_ack),
        .sc_rvalid(sc_rvalid), .sc_done(sc_done),
        .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr),
        .gpu_wdata(gpu_wdata), .gpu_ack(gpu_ack), .gpu_rvalid(gpu_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
        .rdata(rdata), .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hA5C3 ^ {14'h0, a[17:16]};
    endfunction

    function automatic logic [ADDR_W-1:0] rnd_addr();
        return ADDR_W'(32'h3FFE0 + $urandom_range(0, 63));
    endfunction

    // VRAM model: writes land immediately, reads return MEM_LAT cycles later
    initial begin
        forever begin
            @(posedge CLOCK_50);
            #1;
            cyc = cyc + 1;
            if (mem_ce === 1'b1) begin
                if (mem_we === 1'b1) begin
                    env_mem[int'(mem_addr)] = mem_wdata;
                end else begin
                    env_due[cyc + MEM_LAT] = env_mem.exists(int'(mem_addr)) ?
                                             env_mem[int'(mem_addr)] : dflt(mem_addr);
                end
            end
            if (env_due.exists(cyc)) begin
                mem_rdata = env_due[cyc];
                env_due.delete(cyc);
            end else begin
                mem_rdata = 16'($urandom);
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sc_req = 1'b0; gpu_req = 1'b0; cpu_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sc_req = 1'b1; gpu_req = 1'b1; cpu_req = 1'b1;
        sc_addr = 18'h00123; gpu_addr = 18'h00456; cpu_addr = 18'h00789;
        gpu_wdata = 16'hFFFF; cpu_wdata = 16'hFFFF;
        tick();
        tick();
        n_tests++;
        if ({sc_ack, gpu_ack, cpu_ack, sc_rvalid, gpu_rvalid, cpu_rvalid, sc_done, mem_ce, mem_we} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b exp 0", {sc_ack, gpu_ack, cpu_ack, sc_rvalid, gpu_rvalid, cpu_rvalid, sc_done, mem_ce, mem_we});
        end
        n_tests++;
        if ({mem_addr, mem_wdata} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h exp 0", {mem_addr, mem_wdata});
        end
        sc_req = 1'b0; gpu_req = 1'b0; cpu_req = 1'b0;
        reset = 1'b0;
        tick();
        n_tests++;
        if (mem_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: mem_ce got %b exp 0", mem_ce);
        end
    endtask

    task automatic test_cpu_read();
        env_mem[32'h10] = 16'hBEEF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00010;
        tick();
        n_tests++;
        if ({cpu_ack, gpu_ack, mem_ce, mem_we, mem_addr} !== {4'b1010, 18'h00010}) begin
            n_fail++;
            $display("FAIL cpu_read_issue: got %h exp %h", {cpu_ack, gpu_ack, mem_ce, mem_we, mem_addr}, {4'b1010, 18'h00010});
        end
        cpu_req = 1'b0;
        tick();
        n_tests++;
        if ({cpu_ack, cpu_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL cpu_read_early: got %b exp 00", {cpu_ack, cpu_rvalid});
        end
        tick();
        n_tests++;
        if ({cpu_rvalid, gpu_rvalid, sc_rvalid, rdata} !== {3'b100, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL cpu_read_data: got %h exp %h", {cpu_rvalid, gpu_rvalid, sc_rvalid, rdata}, {3'b100, 16'hBEEF});
        end
        tick();
        n_tests++;
        if (cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_read_once: cpu_rvalid got %b exp 0", cpu_rvalid);
        end
    endtask

    task automatic test_gpu_write();
        int extra;
        gpu_req = 1'b1; gpu_we = 1'b1; gpu_addr = 18'h00100; gpu_wdata = 16'h1234;
        tick();
        n_tests++;
        if ({gpu_ack, mem_ce, mem_we, mem_addr, mem_wdata} !== {3'b111, 18'h00100, 16'h1234}) begin
            n_fail++;
            $display("FAIL gpu_write_issue: got %h exp %h", {gpu_ack, mem_ce, mem_we, mem_addr, mem_wdata}, {3'b111, 18'h00100, 16'h1234});
        end
        gpu_req = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            extra += int'(gpu_ack) + int'(gpu_rvalid) + int'(mem_ce);
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL gpu_write_quiet: extra events got %0d exp 0", extra);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00100;
        tick();
        cpu_req = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({cpu_rvalid, rdata} !== {1'b1, 16'h1234}) begin
            n_fail++;
            $display("FAIL gpu_write_readback: got %h exp %h", {cpu_rvalid, rdata}, {1'b1, 16'h1234});
        end
    endtask

    task automatic test_burst_wrap();
        logic [ADDR_W-1:0] a;
        sc_req = 1'b1; sc_addr = 18'h3FFFC;
        for (int i = 0; i < BURST_LEN + MEM_LAT + 2; i++) begin
            tick();
            if (sc_ack === 1'b1) sc_req = 1'b0;
            a = ADDR_W'(32'h3FFFC + i);
            n_tests++;
            if ({mem_ce, sc_ack} !== {(i < BURST_LEN), (i == 0)}) begin
                n_fail++;
                $display("FAIL burst_ce_%0d: got %b exp %b", i, {mem_ce, sc_ack}, {(i < BURST_LEN), (i == 0)});
            end
            if (i < BURST_LEN) begin
                n_tests++;
                if (mem_addr !== a) begin
                    n_fail++;
                    $display("FAIL burst_addr_%0d: got %h exp %h", i, mem_addr, a);
                end
            end
            n_tests++;
            if ({sc_rvalid, sc_done} !== {(i >= MEM_LAT && i < BURST_LEN + MEM_LAT), (i == BURST_LEN + MEM_LAT - 1)}) begin
                n_fail++;
                $display("FAIL burst_rv_%0d: got %b exp %b", i, {sc_rvalid, sc_done}, {(i >= MEM_LAT && i < BURST_LEN + MEM_LAT), (i == BURST_LEN + MEM_LAT - 1)});
            end
            if (i >= MEM_LAT && i < BURST_LEN + MEM_LAT) begin
                a = ADDR_W'(32'h3FFFC + i - MEM_LAT);
                n_tests++;
                if (rdata !== dflt(a)) begin
                    n_fail++;
                    $display("FAIL burst_data_%0d: got %h exp %h", i, rdata, dflt(a));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic exp_g;
        gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 18'h00020;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00030;
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_g = (i % 2 == 0);
            n_tests++;
            if ({gpu_ack, cpu_ack, mem_ce, mem_addr} !== {exp_g, ~exp_g, 1'b1, exp_g ? 18'h00020 : 18'h00030}) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got %h exp %h", i, {gpu_ack, cpu_ack, mem_ce, mem_addr}, {exp_g, ~exp_g, 1'b1, exp_g ? 18'h00020 : 18'h00030});
            end
        end
        gpu_req = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    // Last GPU/CPU grant was the GPU, so after the burst the CPU must go first
    task automatic test_simultaneous();
        sc_req = 1'b1; sc_addr = 18'h00200;
        gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 18'h00040;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00050;
        for (int i = 0; i < BURST_LEN + 4; i++) begin
            tick();
            n_tests++;
            if ({sc_ack, gpu_ack, cpu_ack, mem_ce} !== {(i == 0), (i == BURST_LEN + 1), (i == BURST_LEN), (i <= BURST_LEN + 1)}) begin
                n_fail++;
                $display("FAIL simul_grant_%0d: got %b exp %b", i, {sc_ack, gpu_ack, cpu_ack, mem_ce}, {(i == 0), (i == BURST_LEN + 1), (i == BURST_LEN), (i <= BURST_LEN + 1)});
            end
            if (i < BURST_LEN) begin
                n_tests++;
                if (mem_addr !== ADDR_W'(32'h200 + i)) begin
                    n_fail++;
                    $display("FAIL simul_addr_%0d: got %h exp %h", i, mem_addr, ADDR_W'(32'h200 + i));
                end
            end
            if (sc_ack === 1'b1) sc_req = 1'b0;
            if (gpu_ack === 1'b1) gpu_req = 1'b0;
            if (cpu_ack === 1'b1) cpu_req = 1'b0;
        end
        sc_req = 1'b0; gpu_req = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_mid_burst();
        int extra;
        sc_req = 1'b1; sc_addr = 18'h00400;
        tick();
        sc_req = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (mem_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_burst_ce: got %b exp 0", mem_ce);
        end
        extra = int'(sc_rvalid) + int'(sc_done);
        for (int i = 0; i < 10; i++) begin
            tick();
            extra += int'(sc_rvalid) + int'(sc_done) + int'(mem_ce);
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL rst_burst_quiet: extra events got %0d exp 0", extra);
        end
        gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 18'h00060;
        tick();
        n_tests++;
        if ({gpu_ack, mem_ce, mem_addr} !== {2'b11, 18'h00060}) begin
            n_fail++;
            $display("FAIL rst_burst_idle: got %h exp %h", {gpu_ack, mem_ce, mem_addr}, {2'b11, 18'h00060});
        end
        gpu_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_random();
        logic              e_ce, e_we, e_sc, e_g, e_c, g_ok, c_ok, any_rv;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        int                rd_src;
        bit                rd_last;
        logic [3:0]        e_rv;
        do_reset();
        m_left = 0; m_sc_ack = 1'b0; m_gpu_ack = 1'b0; m_cpu_ack = 1'b0; m_cpu_last = 1'b1;
        exp_src.delete(); exp_data.delete(); exp_last.delete();
        ref_mem = env_mem;
        for (int n = 0; n < 3000; n++) begin
            if (n < 2950) begin
                if (gpu_req && gpu_ack) begin
                    gpu_req = 1'($urandom_range(0, 1));
                    gpu_we = 1'($urandom_range(0, 1)); gpu_addr = rnd_addr(); gpu_wdata = 16'($urandom);
                end else if (!gpu_req && $urandom_range(0, 2) == 0) begin
                    gpu_req = 1'b1;
                    gpu_we = 1'($urandom_range(0, 1)); gpu_addr = rnd_addr(); gpu_wdata = 16'($urandom);
                end
                if (cpu_req && cpu_ack) begin
                    cpu_req = 1'($urandom_range(0, 1));
                    cpu_we = 1'($urandom_range(0, 1)); cpu_addr = rnd_addr(); cpu_wdata = 16'($urandom);
                end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                    cpu_req = 1'b1;
                    cpu_we = 1'($urandom_range(0, 1)); cpu_addr = rnd_addr(); cpu_wdata = 16'($urandom);
                end
                if (sc_req && sc_ack) begin
                    sc_req = 1'($urandom_range(0, 3) == 0);
                    sc_addr = rnd_addr();
                end else if (!sc_req && $urandom_range(0, 19) == 0) begin
                    sc_req = 1'b1;
                    sc_addr = rnd_addr();
                end
            end else begin
                sc_req = 1'b0; gpu_req = 1'b0; cpu_req = 1'b0;
            end
            tick();
            // Predict this edge's command from the arbitration rules
            e_ce = 1'b0; e_we = 1'b0; e_sc = 1'b0; e_g = 1'b0; e_c = 1'b0;
            e_addr = '0; e_wd = '0; rd_src = -1; rd_last = 1'b0;
            g_ok = gpu_req && !m_gpu_ack;
            c_ok = cpu_req && !m_cpu_ack;
            if (m_left > 0) begin
                e_ce = 1'b1; e_addr = m_baddr; rd_src = 0; rd_last = (m_left == 1);
                m_baddr = m_baddr + 18'd1;
                m_left--;
            end else if (sc_req && !m_sc_ack) begin
                e_ce = 1'b1; e_addr = sc_addr; e_sc = 1'b1; rd_src = 0;
                m_left = BURST_LEN - 1;
                m_baddr = sc_addr + 18'd1;
            end else if (g_ok && (!c_ok || m_cpu_last)) begin
                e_ce = 1'b1; e_g = 1'b1; e_we = gpu_we; e_addr = gpu_addr; e_wd = gpu_wdata;
                m_cpu_last = 1'b0;
                if (gpu_we) ref_mem[int'(gpu_addr)] = gpu_wdata;
                else rd_src = 1;
            end else if (c_ok) begin
                e_ce = 1'b1; e_c = 1'b1; e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
                m_cpu_last = 1'b1;
                if (cpu_we) ref_mem[int'(cpu_addr)] = cpu_wdata;
                else rd_src = 2;
            end
            m_sc_ack = e_sc; m_gpu_ack = e_g; m_cpu_ack = e_c;
            if (rd_src >= 0) begin
                exp_src[cyc + MEM_LAT]  = rd_src;
                exp_data[cyc + MEM_LAT] = ref_mem.exists(int'(e_addr)) ? ref_mem[int'(e_addr)] : dflt(e_addr);
                exp_last[cyc + MEM_LAT] = rd_last;
            end
            n_tests++;
            if ({mem_ce, sc_ack, gpu_ack, cpu_ack} !== {e_ce, e_sc, e_g, e_c}) begin
                n_fail++;
                $display("FAIL rand_cmd@%0d: got %b exp %b", n, {mem_ce, sc_ack, gpu_ack, cpu_ack}, {e_ce, e_sc, e_g, e_c});
            end
            if (e_ce) begin
                n_tests++;
                if ({mem_we, mem_addr} !== {e_we, e_addr}) begin
                    n_fail++;
                    $display("FAIL rand_addr@%0d: got %h exp %h", n, {mem_we, mem_addr}, {e_we, e_addr});
                end
                if (e_we) begin
                    n_tests++;
                    if (mem_wdata !== e_wd) begin
                        n_fail++;
                        $display("FAIL rand_wdata@%0d: got %h exp %h", n, mem_wdata, e_wd);
                    end
                end
            end
            any_rv = exp_src.exists(cyc);
            e_rv = 4'b0;
            if (any_rv) begin
                e_rv = {exp_src[cyc] == 0, exp_src[cyc] == 1, exp_src[cyc] == 2, exp_last[cyc]};
            end
            n_tests++;
            if ({sc_rvalid, gpu_rvalid, cpu_rvalid, sc_done} !== e_rv) begin
                n_fail++;
                $display("FAIL rand_rvalid@%0d: got %b exp %b", n, {sc_rvalid, gpu_rvalid, cpu_rvalid, sc_done}, e_rv);
            end
            if (any_rv) begin
                n_tests++;
                if (rdata !== exp_data[cyc]) begin
                    n_fail++;
                    $display("FAIL rand_rdata@%0d: got %h exp %h", n, rdata, exp_data[cyc]);
                end
                exp_src.delete(cyc); exp_data.delete(cyc); exp_last.delete(cyc);
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_cpu_read();
        test_gpu_write();
        test_burst_wrap();
        test_round_robin();
        test_simultaneous();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-clock arbiter that shares one single-port video RAM between three requesters in the SoC: the VGA scanout line prefetcher, the GPU rasterizer and the RISC-V CPU. Scanout always wins and is served as an uninterruptible read burst. GPU and CPU single-word accesses alternate round-robin. Read data is routed back to the issuing requester through a latency-matched tag pipeline.

## Interface
- `ADDR_W`, 18: word address width.
- `DATA_W`, 16: data width.
- `MEM_LAT`, 2: fixed VRAM read latency in cycles, from `mem_ce` to `mem_rdata` valid. Must be ≥1.
- `BURST_LEN`, 8: words per scanout burst. Must be ≥2.

Ports:
- `CLOCK_50`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sc_req`  in  1  scanout burst request; held until `sc_ack`.
- `sc_addr`  in  ADDR_W  burst start address.
- `sc_ack`  out  1  one-cycle pulse when the first burst read issues.
- `sc_rvalid`  out  1  scanout read word valid.
- `sc_done`  out  1  pulse with the last `sc_rvalid` of the burst.
- `gpu_req`, `cpu_req`  in  1  single-word request; held until ack.
- `gpu_we`, `cpu_we`  in  1  1 = write, 0 = read.
- `gpu_addr`, `cpu_addr`  in  ADDR_W  word address.
- `gpu_wdata`, `cpu_wdata`  in  DATA_W  write data.
- `gpu_ack`, `cpu_ack`  out  1  one-cycle pulse when the command issues.
- `gpu_rvalid`, `cpu_rvalid`  out  1  read data valid.
- `rdata`  out  DATA_W  shared read-data bus, qualified by the per-source rvalid.
- `mem_ce`  out  1  VRAM command strobe.
- `mem_we`  out  1  VRAM write enable.
- `mem_addr`  out  ADDR_W  VRAM address.
- `mem_wdata`  out  DATA_W  VRAM write data.
- `mem_rdata`  in  DATA_W  VRAM read data, valid `MEM_LAT` cycles after a read `mem_ce`.

## Operation
- States: IDLE and BURST.
- **IDLE** issues at most one command per cycle, chosen by priority:
  - `sc_req`: issue a read of `sc_addr`, latch `sc_addr`, set count=1, pulse `sc_ack`, go to BURST.
  - Otherwise, GPU/CPU round-robin: if only one requests, serve it. If both request, serve the one not served last.
- **BURST** issues a read of `base+count` every cycle, then increments count. After the read with count=BURST_LEN-1 issues, return to IDLE. The burst is never interrupted; GPU/CPU requests wait.
- Address arithmetic is modulo 2^ADDR_W; a burst wraps from max to 0.
- Writes drive `mem_we=1`, produce no rvalid, and are complete at ack.
- Ack guard: a requester whose ack is high in a cycle is not eligible in that cycle. A requester may keep `req` high after ack to start its next transaction, which is eligible one cycle later.
- Tag pipeline: every read pushes {valid, src} into a MEM_LAT-deep shift register. At the output, `rdata` = `mem_rdata` and the matching `*_rvalid` is asserted.
- `sc_done` is asserted with the BURST_LEN-th scanout rvalid.
- The round-robin pointer updates only on GPU/CPU grants. Scanout grants leave it unchanged.

## Timing
- All outputs are registered except `rdata`, which is combinational from `mem_rdata`.
- Reset values:
  - all acks, rvalids, `sc_done`, `mem_ce`, `mem_we` = 0; `mem_addr` and `mem_wdata` = 0.
  - state = IDLE; count = 0; round-robin pointer favours GPU (treated as if the CPU was served last).
  - tag pipeline cleared.
- Latency:
  - `req` sampled high at edge t → `mem_ce` and ack high in cycle t+1.
  - read data → rvalid high in cycle t+1+MEM_LAT.
- Burst: `mem_ce` is high for BURST_LEN consecutive cycles. Next scanout eligibility is the cycle after the last burst issue.
- Simultaneous requests:
  - scanout + GPU + CPU at the same edge: scanout is granted, and GPU/CPU both wait ≥BURST_LEN cycles.
  - GPU + CPU: they alternate strictly.
- Reset mid-burst or with reads in flight: the burst is aborted and no further rvalid or `sc_done` is emitted.
- Worst-case wait for GPU/CPU under continuous scanout is unbounded. The scanout prefetcher is responsible for leaving gaps.

## Structure
- Package `vram_pkg`:
  - `src_e` (SRC_SCAN, SRC_GPU, SRC_CPU).
  - `arb_state_e` (IDLE, BURST).
  - tag struct {valid, src_e}.
- Sub-module `vram_rd_tag_pipe`: parameterized MEM_LAT shift register of tags, with synchronous clear on `reset`.

## Test plan
- Reset, then CPU read of 0x00010 with `mem_rdata`=0xBEEF → `cpu_ack` at t+1, `cpu_rvalid` with `rdata`=0xBEEF at t+3 (MEM_LAT=2).
- `sc_req` with `sc_addr`=0x3FFFC, BURST_LEN=8 → `mem_addr` sequence 0x3FFFC..0x3FFFF, 0x00000..0x00003 on 8 consecutive cycles, 8 `sc_rvalid`, `sc_done` on the 8th.
- GPU and CPU both holding requests continuously → grants GPU, CPU, GPU, CPU…, one command every cycle (each requester served every 2nd cycle), no double issue.
- `sc_req`, `gpu_req` and `cpu_req` rise at the same edge → scanout burst first. GPU is acked in the cycle after the last burst issue; the round-robin pointer is unchanged by the burst.
- GPU write (addr 0x00100, data 0x1234) → `mem_ce`=1, `mem_we`=1 for one cycle, `gpu_ack` once, no `gpu_rvalid`.
- `reset` asserted on the 4th burst cycle → `mem_ce` low next cycle; no `sc_rvalid` or `sc_done` afterwards; state IDLE.
